cmd_responder: RTL
==================

# cmd_responder

Card-side endpoint of the SD CMD line, the counterpart to the host CMD driver. Receives 48-bit host command frames one bit per `iclk`, checks framing and CRC7, and presents index/argument to the card model. It then serializes a short (48-bit), long (136-bit) or no response after the N_CR gap. Used by the SD card emulator and the transceiver loopback bench.

## Interface
- `NCR`, default 2: idle-high cycles between the host end bit and the response start bit (2..64).
- `NCR_MAX`, default 64: `iresp_valid` deadline, counted from the host end bit.
- `irst`  in  1  global reset; synchronous, active-high.
- `iclk`  in  1  system clock; one CMD bit per cycle.
- `iocmd_sd`  inout  1  CMD line; driven only while responding, otherwise `z`.
- `ocmd_valid`  out  1  one-cycle pulse: a valid command was received.
- `ocmd_index`  out  6  command index; held until the next valid command.
- `ocmd_arg`  out  32  command argument; held until the next valid command.
- `ocrc_err`  out  1  one-cycle pulse: CRC7 mismatch or bad end bit.
- `iresp_valid`  in  1  response descriptor valid; sampled only in WAIT_NCR.
- `iresp_kind`  in  2  00 none, 01 short, 10 long, 11 treated as none.
- `iresp_index`  in  6  short-response index field.
- `iresp_payload`  in  120  short response uses [119:88]; long response uses all 120 bits.
- `oresp_done`  out  1  one-cycle pulse after the response end bit.
- `obusy`  out  1  high in any state other than IDLE.
- Reset values: all outputs 0, `iocmd_sd` released (`z`).

## Operation
- IDLE: wait for `iocmd_sd` == 0 (start bit). Go to RCV_CMD with bit count 47 remaining.
- RCV_CMD: shift each sampled bit into a 47-bit register.
  - The first bit after the start bit (transmission bit) must be 1. If it is 0, abort to RESYNC with no error pulse.
  - CRC7 accumulates over start + 39 bits (40 total). The next 7 bits are compared with it; the last bit is the end bit.
- CHECK (1 cycle):
  - CRC7 match and end bit 1: latch index/arg, pulse `ocmd_valid`, go to WAIT_NCR.
  - Otherwise: pulse `ocrc_err`, go to IDLE. No response is sent; the host retries.
- WAIT_NCR:
  - Count cycles from the host end bit. Latch the descriptor on the first `iresp_valid` seen.
  - Once the count ≥ NCR and a descriptor is latched: kind none → IDLE with `oresp_done` pulse; short or long → SEND.
  - If the count reaches NCR_MAX with no descriptor: return to IDLE silently.
- SEND: drive the frame MSB first.
  - Short frame: 0, 0, `iresp_index`, payload[119:88], CRC7 over the preceding 40 bits, 1.
  - Long frame: 0, 0, 6'b111111, payload[119:0], CRC7 over the 120 payload bits, 1.
  - Bit counter is 47 (short) or 135 (long).
- END: after the end bit is driven, release the line, pulse `oresp_done`, go to IDLE.
- RESYNC: wait for `iocmd_sd` == 1, then go to IDLE. A line held low never produces a false frame.
- The line is driven only in SEND/END, never at the same time as the host.
- Reset in any state: IDLE on the next edge, line released in that cycle, latched descriptor cleared. `ocmd_index`/`ocmd_arg` clear to 0.

## Timing
- Command input: start bit at cycle 0, end bit sampled at cycle 47.
- CHECK occupies cycle 48. `ocmd_valid`/`ocrc_err` are registered and high during cycle 49.
- With `iresp_valid` high at cycle 49 and NCR=2: response start bit is driven at cycle 48+NCR+1 = 51. The end bit is driven 47 (short) or 135 (long) cycles later.
- `oresp_done` is high in the cycle after the end bit. `obusy` drops in that same cycle.
- A start bit arriving while responding is ignored; the host must not issue one.
- A `iresp_valid` pulse outside WAIT_NCR is ignored.

## Structure
- Shared package `sd_pkg`: response kind codes, frame lengths (48, 136), `R2_HEADER` = 6'b111111, NCR limits.
- Sub-module: the existing serial `crc7` generator. Instantiate two: one for the receive check, one for transmit generation.
  - Reset each at its frame start.
  - On transmit, use its unload mode for the 7 CRC bits.
- Parameter check: elaboration error if NCR < 2 or NCR > NCR_MAX.

## Test plan
- CMD0 frame 0x40_0000_0000_95, kind none, `iresp_valid` at cycle 49 → one `ocmd_valid` pulse with index 0, arg 0; no line drive; `oresp_done` at cycle 51.
- CMD8 frame 0x48_0000_01AA_87, short response, index 8, payload[119:88] = 0x000001AA → `ocmd_arg` = 0x1AA. Start bit at cycle 51; 48-bit frame matches the bench CRC7 model; end bit 1; line `z` afterwards.
- CMD2 with long response, payload 0x1122…EE (120 bits) → header 0x3F, 136 bits total, CRC7 over the payload matches the model, `oresp_done` once.
- CMD8 with arg bit 0 flipped → `ocrc_err` pulse, no `ocmd_valid`, no response. An immediate correct retransmit is answered normally.
- Frame with transmission bit 0 (echo of a response), then the line held low for 20 cycles → no pulses, stays in RESYNC until the line goes high.
- `irst` asserted at response bit 20 → line released on the next edge; `obusy`, `oresp_done`, `ocmd_index` all 0. The next CMD0 is received correctly.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared SD CMD-line definitions: response kinds, frame lengths, N_CR limits.
package sd_pkg;

   localparam int unsigned CMD_LEN        = 48;
   localparam int unsigned SHORT_LEN      = 48;
   localparam int unsigned LONG_LEN       = 136;
   localparam int unsigned SHORT_DATA_LEN = 40;   // bits covered by the short-frame CRC region
   localparam int unsigned LONG_DATA_LEN  = 128;  // start, tx, header and payload of a long frame
   localparam int unsigned R2_HDR_END     = 8;    // first payload bit index of a long frame
   localparam int unsigned CRC_W          = 7;
   localparam int unsigned NCR_MIN        = 2;
   localparam int unsigned NCR_LIMIT      = 64;

   localparam logic [5:0] R2_HEADER = 6'b111111;

   typedef enum logic [1:0] {
      RESP_NONE  = 2'b00,
      RESP_SHORT = 2'b01,
      RESP_LONG  = 2'b10,
      RESP_RSVD  = 2'b11
   } resp_kind_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RCV_CMD,
      ST_CHECK,
      ST_WAIT_NCR,
      ST_SEND,
      ST_END,
      ST_RESYNC
   } state_e;

   typedef struct packed {
      resp_kind_e   kind;
      logic [5:0]   index;
      logic [119:0] payload;
   } resp_desc_t;

endpackage

// File: rtl/crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) generator with clear and MSB-first unload modes.
module crc7 (
   input  logic       iclk,
   input  logic       irst,
   input  logic       iclr,
   input  logic       ien,
   input  logic       iunload,
   input  logic       idin,
   output logic [6:0] ocrc
);

   logic [6:0] crc_q;
   logic [6:0] crc_d;
   logic       fb_c;

   always_comb begin
      fb_c  = idin ^ crc_q[6];
      crc_d = crc_q;
      if (iclr) begin
         crc_d = '0;
      end else if (iunload) begin
         crc_d = {crc_q[5:0], 1'b0};
      end else if (ien) begin
         crc_d = {crc_q[5:3], crc_q[2] ^ fb_c, crc_q[1:0], fb_c};
      end
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign ocrc = crc_q;

endmodule

// File: rtl/cmd_responder.sv
// Card-side SD CMD endpoint: receives and checks 48-bit host commands,
// then serialises a none/short/long response after the N_CR gap.
module cmd_responder
   import sd_pkg::*;
#(
   parameter int unsigned NCR     = 2,
   parameter int unsigned NCR_MAX = 64
) (
   input  logic         iclk,
   input  logic         irst,
   inout  wire          iocmd_sd,
   output logic         ocmd_valid,
   output logic [5:0]   ocmd_index,
   output logic [31:0]  ocmd_arg,
   output logic         ocrc_err,
   input  logic         iresp_valid,
   input  logic [1:0]   iresp_kind,
   input  logic [5:0]   iresp_index,
   input  logic [119:0] iresp_payload,
   output logic         oresp_done,
   output logic         obusy
);

   if (NCR < NCR_MIN || NCR > NCR_MAX || NCR_MAX > NCR_LIMIT) begin : g_bad_ncr
      $error("cmd_responder: NCR must lie in 2..NCR_MAX and NCR_MAX must not exceed 64");
   end

   localparam logic [6:0] NCR_B        = 7'(NCR);
   localparam logic [6:0] NCR_MAX_B    = 7'(NCR_MAX);
   localparam logic [5:0] RX_BITS      = 6'(CMD_LEN - 1);
   localparam logic [5:0] RX_CRC_LAST  = 6'(CRC_W + 2);
   localparam logic [7:0] SHORT_DATA_B = 8'(SHORT_DATA_LEN);
   localparam logic [7:0] LONG_DATA_B  = 8'(LONG_DATA_LEN);
   localparam logic [7:0] HDR_END_B    = 8'(R2_HDR_END);
   localparam logic [7:0] CRC_W_B      = 8'(CRC_W);

   state_e       state_q,      state_d;
   logic [5:0]   rem_q,        rem_d;
   logic [46:0]  rx_sr_q,      rx_sr_d;
   logic [5:0]   cmd_index_q,  cmd_index_d;
   logic [31:0]  cmd_arg_q,    cmd_arg_d;
   logic         cmd_valid_q,  cmd_valid_d;
   logic         crc_err_q,    crc_err_d;
   logic [6:0]   ncr_cnt_q,    ncr_cnt_d;
   logic         desc_vld_q,   desc_vld_d;
   resp_desc_t   desc_q,       desc_d;
   logic [127:0] tx_sr_q,      tx_sr_d;
   logic [7:0]   tx_idx_q,     tx_idx_d;
   logic         tx_long_q,    tx_long_d;
   logic         drive_q,      drive_d;
   logic         bit_q,        bit_d;
   logic         done_q,       done_d;
   logic         busy_q,       busy_d;

   logic         cmd_line_c;
   logic         rx_clr_c;
   logic         rx_en_c;
   logic [6:0]   rx_crc;
   logic         tx_start_c;
   logic         tx_feed_c;
   logic         tx_unload_c;
   logic [6:0]   tx_crc;
   logic [7:0]   nxt_idx_c;
   logic [7:0]   data_len_c;
   logic         unused_tx_crc;

   assign cmd_line_c    = iocmd_sd;
   assign iocmd_sd      = drive_q ? bit_q : 1'bz;
   assign unused_tx_crc = ^tx_crc[5:0];

   // Receive check: cleared while idle, so the zero start bit leaves it at 0.
   assign rx_clr_c = (state_q == ST_IDLE);
   assign rx_en_c  = (state_q == ST_RCV_CMD) && (rem_q >= RX_CRC_LAST);

   crc7 u_crc_rx (
      .iclk    (iclk),
      .irst    (irst),
      .iclr    (rx_clr_c),
      .ien     (rx_en_c),
      .iunload (1'b0),
      .idin    (cmd_line_c),
      .ocrc    (rx_crc)
   );

   crc7 u_crc_tx (
      .iclk    (iclk),
      .irst    (irst),
      .iclr    (tx_start_c),
      .ien     (tx_feed_c),
      .iunload (tx_unload_c),
      .idin    (bit_d),
      .ocrc    (tx_crc)
   );

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      rx_sr_d     = rx_sr_q;
      cmd_index_d = cmd_index_q;
      cmd_arg_d   = cmd_arg_q;
      cmd_valid_d = 1'b0;
      crc_err_d   = 1'b0;
      ncr_cnt_d   = ncr_cnt_q;
      desc_vld_d  = desc_vld_q;
      desc_d      = desc_q;
      tx_sr_d     = tx_sr_q;
      tx_idx_d    = tx_idx_q;
      tx_long_d   = tx_long_q;
      drive_d     = drive_q;
      bit_d       = bit_q;
      done_d      = 1'b0;
      tx_start_c  = 1'b0;
      tx_feed_c   = 1'b0;
      tx_unload_c = 1'b0;
      nxt_idx_c   = tx_idx_q + 8'd1;
      data_len_c  = tx_long_q ? LONG_DATA_B : SHORT_DATA_B;

      case (state_q)
         ST_IDLE: begin
            if (!cmd_line_c) begin
               state_d = ST_RCV_CMD;
               rem_d   = RX_BITS;
            end
         end

         ST_RCV_CMD: begin
            rx_sr_d = {rx_sr_q[45:0], cmd_line_c};
            rem_d   = rem_q - 6'd1;
            // A zero transmission bit means we are hearing a response, not a command.
            if (rem_q == RX_BITS && !cmd_line_c) begin
               state_d = ST_RESYNC;
            end else if (rem_q == 6'd1) begin
               state_d = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (rx_sr_q[46] && rx_sr_q[0] && (rx_sr_q[7:1] == rx_crc)) begin
               cmd_index_d = rx_sr_q[45:40];
               cmd_arg_d   = rx_sr_q[39:8];
               cmd_valid_d = 1'b1;
               ncr_cnt_d   = 7'd1;
               desc_vld_d  = 1'b0;
               state_d     = ST_WAIT_NCR;
            end else begin
               crc_err_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end

         ST_WAIT_NCR: begin
            if (ncr_cnt_q < NCR_MAX_B) begin
               ncr_cnt_d = ncr_cnt_q + 7'd1;
            end
            if (iresp_valid && !desc_vld_q) begin
               desc_vld_d     = 1'b1;
               desc_d.kind    = resp_kind_e'(iresp_kind);
               desc_d.index   = iresp_index;
               desc_d.payload = iresp_payload;
            end
            if (desc_vld_q && ncr_cnt_q >= NCR_B) begin
               desc_vld_d = 1'b0;
               case (desc_q.kind)
                  RESP_SHORT: begin
                     tx_sr_d    = {1'b0, desc_q.index, desc_q.payload[119:88], 89'b0};
                     tx_long_d  = 1'b0;
                     tx_start_c = 1'b1;
                  end
                  RESP_LONG: begin
                     tx_sr_d    = {1'b0, R2_HEADER, desc_q.payload, 1'b0};
                     tx_long_d  = 1'b1;
                     tx_start_c = 1'b1;
                  end
                  default: begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               endcase
               if (tx_start_c) begin
                  tx_idx_d = 8'd0;
                  drive_d  = 1'b1;
                  bit_d    = 1'b0;
                  state_d  = ST_SEND;
               end
            end else if (!desc_vld_q && ncr_cnt_q >= NCR_MAX_B) begin
               state_d = ST_IDLE;
            end
         end

         ST_SEND: begin
            tx_idx_d = nxt_idx_c;
            if (nxt_idx_c < data_len_c) begin
               bit_d     = tx_sr_q[127];
               tx_sr_d   = {tx_sr_q[126:0], 1'b0};
               // Long-frame CRC covers only the payload, not the start/tx/header bits.
               tx_feed_c = !tx_long_q || (nxt_idx_c >= HDR_END_B);
            end else if (nxt_idx_c < data_len_c + CRC_W_B) begin
               bit_d       = tx_crc[6];
               tx_unload_c = 1'b1;
            end else begin
               bit_d   = 1'b1;
               state_d = ST_END;
            end
         end

         ST_END: begin
            drive_d = 1'b0;
            bit_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         ST_RESYNC: begin
            if (cmd_line_c) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            drive_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         rx_sr_q     <= '0;
         cmd_index_q <= '0;
         cmd_arg_q   <= '0;
         cmd_valid_q <= 1'b0;
         crc_err_q   <= 1'b0;
         ncr_cnt_q   <= '0;
         desc_vld_q  <= 1'b0;
         desc_q      <= '0;
         tx_sr_q     <= '0;
         tx_idx_q    <= '0;
         tx_long_q   <= 1'b0;
         drive_q     <= 1'b0;
         bit_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         rx_sr_q     <= rx_sr_d;
         cmd_index_q <= cmd_index_d;
         cmd_arg_q   <= cmd_arg_d;
         cmd_valid_q <= cmd_valid_d;
         crc_err_q   <= crc_err_d;
         ncr_cnt_q   <= ncr_cnt_d;
         desc_vld_q  <= desc_vld_d;
         desc_q      <= desc_d;
         tx_sr_q     <= tx_sr_d;
         tx_idx_q    <= tx_idx_d;
         tx_long_q   <= tx_long_d;
         drive_q     <= drive_d;
         bit_q       <= bit_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign ocmd_valid = cmd_valid_q;
   assign ocmd_index = cmd_index_q;
   assign ocmd_arg   = cmd_arg_q;
   assign ocrc_err   = crc_err_q;
   assign oresp_done = done_q;
   assign obusy      = busy_q;

endmodule
